adc_serial_responder: RTL

Synthesizable responder for the serial ADC link: it sits on the ADC side of the wires driven by the ADC controller (`conv`, `ADCclk`, `ADC_in`) and answers on `ADC_out`. It decodes the start bit and 3-bit channel address shifted in by the controller, fetches a 10-bit sample for that channel from a local source, and shifts it back MSB first. It is used for on-FPGA loopback of the ADC front end and as the bit-accurate device model in controller benches.

---
 rtl/adc_serial_pkg.sv | 20 ++
 rtl/adc_clk_edge.sv | 24 ++
 rtl/adc_serial_responder.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/adc_serial_pkg.sv
// Shared constants for the serial ADC responder: widths, framing constants and FSM encoding.
package adc_serial_pkg;

    localparam int unsigned DATA_W = 10;
    localparam int unsigned ADDR_W = 3;

    localparam logic START_BIT = 1'b1;

    // bit_cnt_r value once every data bit has been driven, and index of the last address bit
    localparam logic [3:0] DATA_CNT  = 4'd10;
    localparam logic [3:0] ADDR_LAST = 4'd2;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_START = 3'd1;
    localparam logic [2:0] ST_ADDR  = 3'd2;
    localparam logic [2:0] ST_NULL  = 3'd3;
    localparam logic [2:0] ST_DATA  = 3'd4;
    localparam logic [2:0] ST_HOLD  = 3'd5;

endpackage

// File: rtl/adc_clk_edge.sv
// Edge detector for the controller's serial bit clock, sampled in the system clock domain.
module adc_clk_edge (
    input  logic clk,
    input  logic rst,
    input  logic adc_clk,
    output logic rise,
    output logic fall
);

    logic adcclk_q;

    // one-cycle history of the serial clock
    always_ff @(posedge clk) begin
        if (rst) begin
            adcclk_q <= 1'b0;
        end else begin
            adcclk_q <= adc_clk;
        end
    end

    assign rise = adc_clk & ~adcclk_q;
    assign fall = ~adc_clk & adcclk_q;

endmodule

// File: rtl/adc_serial_responder.sv
// ADC-side responder: decodes start bit and channel address, then shifts the
// channel's sample back MSB first on the falling edges of the serial clock.
module adc_serial_responder
    import adc_serial_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              ADCclk,
    input  logic              conv,
    input  logic              ADC_in,
    output logic              ADC_out,
    input  logic [DATA_W-1:0] sample_in,
    output logic [ADDR_W-1:0] ch_sel,
    output logic              ch_strobe,
    output logic              busy,
    output logic              frame_err
);

    logic              rise_s;
    logic              fall_s;
    logic [2:0]        state_r,   state_nx_s;
    logic [3:0]        bit_cnt_r, bit_cnt_nx_s;
    logic [ADDR_W-1:0] ch_sel_r,  ch_sel_nx_s;
    logic [DATA_W-1:0] shreg_r,   shreg_nx_s;
    logic              adc_out_r, adc_out_nx_s;
    logic              strobe_r,  strobe_nx_s;
    logic              err_r,     err_nx_s;
    logic              busy_r;

    adc_clk_edge u_edge (
        .clk     (clk),
        .rst     (rst),
        .adc_clk (ADCclk),
        .rise    (rise_s),
        .fall    (fall_s)
    );

    // frame sequencing; in NULL, bit_cnt_r==1 marks that the null bit (and sample capture) has been seen
    always_comb begin
        state_nx_s   = state_r;
        bit_cnt_nx_s = bit_cnt_r;
        ch_sel_nx_s  = ch_sel_r;
        shreg_nx_s   = shreg_r;
        adc_out_nx_s = adc_out_r;
        strobe_nx_s  = 1'b0;
        err_nx_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                adc_out_nx_s = 1'b0;
                if (conv) begin
                    state_nx_s = ST_START;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (!conv) begin
                    state_nx_s   = ST_IDLE;
                    adc_out_nx_s = 1'b0;
                end else if (rise_s && (ADC_in == START_BIT)) begin
                    state_nx_s   = ST_ADDR;
                    bit_cnt_nx_s = 4'd0;
                end else begin
                    state_nx_s = ST_START;
                end
            end
            ST_ADDR: begin
                if (!conv) begin
                    state_nx_s   = ST_IDLE;
                    adc_out_nx_s = 1'b0;
                    err_nx_s     = 1'b1;
                end else if (rise_s) begin
                    ch_sel_nx_s = {ch_sel_r[ADDR_W-2:0], ADC_in};
                    if (bit_cnt_r == ADDR_LAST) begin
                        state_nx_s   = ST_NULL;
                        bit_cnt_nx_s = 4'd0;
                        strobe_nx_s  = 1'b1;
                    end else begin
                        bit_cnt_nx_s = bit_cnt_r + 4'd1;
                    end
                end else begin
                    state_nx_s = ST_ADDR;
                end
            end
            ST_NULL: begin
                if (!conv) begin
                    state_nx_s   = ST_IDLE;
                    adc_out_nx_s = 1'b0;
                    err_nx_s     = 1'b1;
                end else if (rise_s) begin
                    shreg_nx_s   = sample_in;
                    bit_cnt_nx_s = 4'd1;
                end else if (fall_s && (bit_cnt_r == 4'd1)) begin
                    adc_out_nx_s = shreg_r[DATA_W-1];
                    shreg_nx_s   = {shreg_r[DATA_W-2:0], 1'b0};
                    state_nx_s   = ST_DATA;
                end else begin
                    state_nx_s = ST_NULL;
                end
            end
            ST_DATA: begin
                if (!conv) begin
                    state_nx_s   = ST_IDLE;
                    adc_out_nx_s = 1'b0;
                    err_nx_s     = 1'b1;
                end else if (fall_s) begin
                    if (bit_cnt_r == DATA_CNT) begin
                        adc_out_nx_s = 1'b0;
                        state_nx_s   = ST_HOLD;
                    end else begin
                        adc_out_nx_s = shreg_r[DATA_W-1];
                        shreg_nx_s   = {shreg_r[DATA_W-2:0], 1'b0};
                        bit_cnt_nx_s = bit_cnt_r + 4'd1;
                    end
                end else begin
                    state_nx_s = ST_DATA;
                end
            end
            ST_HOLD: begin
                adc_out_nx_s = 1'b0;
                if (!conv) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_HOLD;
                end
            end
            default: begin
                state_nx_s   = ST_IDLE;
                adc_out_nx_s = 1'b0;
            end
        endcase
    end

    // state and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            bit_cnt_r <= 4'd0;
            ch_sel_r  <= {ADDR_W{1'b0}};
            shreg_r   <= {DATA_W{1'b0}};
            adc_out_r <= 1'b0;
            strobe_r  <= 1'b0;
            err_r     <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            state_r   <= state_nx_s;
            bit_cnt_r <= bit_cnt_nx_s;
            ch_sel_r  <= ch_sel_nx_s;
            shreg_r   <= shreg_nx_s;
            adc_out_r <= adc_out_nx_s;
            strobe_r  <= strobe_nx_s;
            err_r     <= err_nx_s;
            busy_r    <= (state_nx_s != ST_IDLE);
        end
    end

    assign ADC_out   = adc_out_r;
    assign ch_sel    = ch_sel_r;
    assign ch_strobe = strobe_r;
    assign busy      = busy_r;
    assign frame_err = err_r;

endmodule
